// File: rtl/picorv_hpdc_adapter.sv
// rtl/picorv_hpdc_adapter.sv - PicoRV32 native memory port to HPDcache request/response bridge
// One outstanding transaction, rolling tid, address-derived uncacheable flag, bounded response wait.
module picorv_hpdc_adapter #(
  parameter int unsigned TidWidth      = 4,
  parameter logic [31:0] UncachedBase  = 32'h8000_0000,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                mem_valid_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic                mem_ready_o,
  output logic [31:0]         mem_rdata_o,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic [31:0]         req_addr_o,
  output logic                req_op_o,
  output logic [31:0]         req_wdata_o,
  output logic [3:0]          req_be_o,
  output logic [1:0]          req_size_o,
  output logic [TidWidth-1:0] req_tid_o,
  output logic                req_uncacheable_o,
  output logic                req_abort_o,
  input  logic                rsp_valid_i,
  input  logic [TidWidth-1:0] rsp_tid_i,
  input  logic [31:0]         rsp_rdata_i,
  input  logic                rsp_error_i,
  output logic                err_o
);

  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CntWidth-1:0] cnt_q;
  logic                rsp_hit;
  logic                timeout_hit;
  logic [3:0]          enc_be;
  logic [1:0]          enc_size;
  logic [1:0]          enc_off;

  // The offset is taken from the strobe pattern, so the core's low address bits are redundant.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_i[1:0];

  assign rsp_hit     = rsp_valid_i && (rsp_tid_i == req_tid_o);
  assign timeout_hit = (cnt_q == CntLast);

  assign req_valid_o = (state_q == REQ);
  assign mem_ready_o = (state_q == DONE);
  assign req_abort_o = 1'b0;

  always_comb begin
    enc_be   = mem_wstrb_i;
    enc_size = 2'd2;
    enc_off  = 2'd0;
    case (mem_wstrb_i)
      4'h0: enc_be = 4'hF;
      4'h3: enc_size = 2'd1;
      4'hC: begin
        enc_size = 2'd1;
        enc_off  = 2'd2;
      end
      4'h1: enc_size = 2'd0;
      4'h2: begin
        enc_size = 2'd0;
        enc_off  = 2'd1;
      end
      4'h4: begin
        enc_size = 2'd0;
        enc_off  = 2'd2;
      end
      4'h8: begin
        enc_size = 2'd0;
        enc_off  = 2'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (mem_valid_i) state_d = REQ;
      REQ:      if (req_ready_i) state_d = WAIT_RSP;
      WAIT_RSP: if (rsp_hit || timeout_hit) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Request fields are captured already encoded so every req_* output is a plain register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_addr_o        <= '0;
      req_op_o          <= 1'b0;
      req_wdata_o       <= '0;
      req_be_o          <= '0;
      req_size_o        <= '0;
      req_uncacheable_o <= 1'b0;
      req_tid_o         <= '0;
      mem_rdata_o       <= '0;
      err_o             <= 1'b0;
      cnt_q             <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid_i) begin
            req_addr_o        <= {mem_addr_i[31:2], enc_off};
            req_op_o          <= |mem_wstrb_i;
            req_wdata_o       <= mem_wdata_i;
            req_be_o          <= enc_be;
            req_size_o        <= enc_size;
            req_uncacheable_o <= (mem_addr_i >= UncachedBase);
          end
        end
        REQ: begin
          if (req_ready_i) cnt_q <= '0;
        end
        WAIT_RSP: begin
          cnt_q <= cnt_q + CntWidth'(1);
          // A matching response wins over a timeout landing in the same cycle.
          if (rsp_hit) begin
            mem_rdata_o <= rsp_rdata_i;
            err_o       <= err_o | rsp_error_i;
          end else if (timeout_hit) begin
            mem_rdata_o <= 32'hDEAD_BEEF;
            err_o       <= 1'b1;
          end
        end
        DONE: begin
          req_tid_o <= req_tid_o + TidWidth'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
